// File: rtl/axi_lite_xbar_cfg_ctrl.sv
// Runtime configuration controller for axi_lite_xbar: an AXI4-Lite programmed shadow
// register set that is swapped into the active set once crossbar traffic has drained.

package axi_lite_xbar_cfg_ctrl_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } cfg_rule_t;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        r_ready;
  } cfg_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } cfg_rsp_t;

  typedef enum logic [1:0] {StIdle = 2'd0, StDrain = 2'd1, StCommit = 2'd2} state_e;
  typedef enum logic [2:0] {RegNone, RegCtrl, RegStatus, RegDefEn, RegDefPort, RegRule} reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [5:0] idx;
    logic [1:0] fld;
  } reg_dec_t;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
endpackage

module axi_lite_xbar_cfg_ctrl
  import axi_lite_xbar_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NoSlvPorts  = 1,
  parameter int unsigned NoMstPorts  = 2,
  parameter int unsigned NoAddrRules = 1,
  parameter int unsigned MaxTrans    = 8,
  parameter type axi_lite_req_t      = cfg_req_t,
  parameter type axi_lite_rsp_t      = cfg_rsp_t,
  parameter type rule_t              = cfg_rule_t,
  localparam int unsigned MstIdxWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  axi_lite_req_t                           cfg_req_i,
  output axi_lite_rsp_t                           cfg_rsp_o,
  input  logic [NoSlvPorts-1:0]                   aw_hs_i,
  input  logic [NoSlvPorts-1:0]                   b_hs_i,
  input  logic [NoSlvPorts-1:0]                   ar_hs_i,
  input  logic [NoSlvPorts-1:0]                   r_hs_i,
  output logic [NoSlvPorts-1:0]                   gate_o,
  output rule_t [NoAddrRules-1:0]                 addr_map_o,
  output logic [NoSlvPorts-1:0]                   en_default_mst_port_o,
  output logic [NoSlvPorts-1:0][MstIdxWidth-1:0]  default_mst_port_o,
  output logic                                    busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

  state_e                                 state_q;
  logic                                   busy_q;
  logic [NoSlvPorts-1:0]                  gate_q;
  logic [NoSlvPorts-1:0][CntWidth-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  rule_t [NoAddrRules-1:0]                sh_map_q, act_map_q;
  logic [NoSlvPorts-1:0]                  sh_en_q, act_en_q;
  logic [NoSlvPorts-1:0][MstIdxWidth-1:0] sh_port_q, act_port_q;
  logic                                   b_valid_q, r_valid_q;
  logic [1:0]                             b_resp_q, r_resp_q;
  logic [31:0]                            r_data_q, rd_data_c;
  reg_dec_t                               wdec, rdec;
  logic                                   wr_hs_c, rd_hs_c, commit_wr_c, drained_c;
  logic                                   unused_ok;

  // Word-aligned decode of the register map; anything unmapped yields RegNone.
  function automatic reg_dec_t decode(input logic [31:0] addr);
    reg_dec_t   d;
    logic [5:0] port_idx;
    d          = '0;
    d.sel      = RegNone;
    d.fld      = addr[3:2];
    port_idx   = addr[7:2] - 6'd16;
    if (addr[31:9] == '0 && addr[1:0] == 2'b00) begin
      if (addr[8]) begin
        if (addr[3:2] != 2'b11 && 32'(addr[7:4]) < NoAddrRules) begin
          d.sel = RegRule;
          d.idx = 6'(addr[7:4]);
        end
      end else if (addr[7:6] != 2'b00) begin
        if (32'(port_idx) < NoSlvPorts) begin
          d.sel = RegDefPort;
          d.idx = port_idx;
        end
      end else begin
        case (addr[5:2])
          4'd0:    d.sel = RegCtrl;
          4'd1:    d.sel = RegStatus;
          4'd2:    d.sel = RegDefEn;
          default: d.sel = RegNone;
        endcase
      end
    end
    return d;
  endfunction

  // Saturating outstanding counter; a simultaneous inc/dec cancels out.
  function automatic logic [CntWidth-1:0] cnt_step(input logic [CntWidth-1:0] cnt,
                                                   input logic inc, input logic dec);
    if (inc && !dec && cnt != CntWidth'(MaxTrans)) return cnt + 1'b1;
    if (dec && !inc && cnt != '0) return cnt - 1'b1;
    return cnt;
  endfunction

  assign wr_hs_c     = cfg_req_i.aw_valid && cfg_req_i.w_valid && !b_valid_q;
  assign rd_hs_c     = cfg_req_i.ar_valid && !r_valid_q;
  assign wdec        = decode(cfg_req_i.aw_addr);
  assign rdec        = decode(cfg_req_i.ar_addr);
  assign commit_wr_c = wr_hs_c && (wdec.sel == RegCtrl) && cfg_req_i.w_data[0];
  assign drained_c   = (wcnt_d == '0) && (rcnt_d == '0);
  assign unused_ok   = ^{cfg_req_i.aw_prot, cfg_req_i.ar_prot, cfg_req_i.w_strb};

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    for (int unsigned i = 0; i < NoSlvPorts; i++) begin
      wcnt_d[i] = cnt_step(wcnt_q[i], aw_hs_i[i], b_hs_i[i]);
      rcnt_d[i] = cnt_step(rcnt_q[i], ar_hs_i[i], r_hs_i[i]);
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (rdec.sel)
      RegStatus: rd_data_c = 32'({state_q, busy_q});
      RegDefEn:  rd_data_c = 32'(sh_en_q);
      RegDefPort: begin
        for (int unsigned i = 0; i < NoSlvPorts; i++)
          if (32'(rdec.idx) == i) rd_data_c = 32'(sh_port_q[i]);
      end
      RegRule: begin
        for (int unsigned r = 0; r < NoAddrRules; r++) begin
          if (32'(rdec.idx) == r) begin
            case (rdec.fld)
              2'd0:    rd_data_c = 32'(sh_map_q[r].idx);
              2'd1:    rd_data_c = 32'(sh_map_q[r].start_addr);
              default: rd_data_c = 32'(sh_map_q[r].end_addr);
            endcase
          end
        end
      end
      default: rd_data_c = '0;
    endcase
  end

  always_comb begin
    cfg_rsp_o          = '0;
    cfg_rsp_o.aw_ready = wr_hs_c;
    cfg_rsp_o.w_ready  = wr_hs_c;
    cfg_rsp_o.b_valid  = b_valid_q;
    cfg_rsp_o.b_resp   = b_resp_q;
    cfg_rsp_o.ar_ready = rd_hs_c;
    cfg_rsp_o.r_valid  = r_valid_q;
    cfg_rsp_o.r_data   = r_data_q;
    cfg_rsp_o.r_resp   = r_resp_q;
  end

  // Register port responses and shadow register writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      r_valid_q <= 1'b0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
      sh_map_q  <= '0;
      sh_en_q   <= '0;
      sh_port_q <= '0;
    end else begin
      if (wr_hs_c) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= (wdec.sel == RegNone) ? RespSlvErr : RespOkay;
      end else if (cfg_req_i.b_ready) begin
        b_valid_q <= 1'b0;
      end
      if (rd_hs_c) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data_c;
        r_resp_q  <= (rdec.sel == RegNone) ? RespSlvErr : RespOkay;
      end else if (cfg_req_i.r_ready) begin
        r_valid_q <= 1'b0;
      end
      if (wr_hs_c) begin
        case (wdec.sel)
          RegDefEn: sh_en_q <= cfg_req_i.w_data[NoSlvPorts-1:0];
          RegDefPort: begin
            for (int unsigned i = 0; i < NoSlvPorts; i++)
              if (32'(wdec.idx) == i) sh_port_q[i] <= cfg_req_i.w_data[MstIdxWidth-1:0];
          end
          RegRule: begin
            for (int unsigned r = 0; r < NoAddrRules; r++) begin
              if (32'(wdec.idx) == r) begin
                case (wdec.fld)
                  2'd0:    sh_map_q[r].idx        <= cfg_req_i.w_data;
                  2'd1:    sh_map_q[r].start_addr <= cfg_req_i.w_data;
                  default: sh_map_q[r].end_addr   <= cfg_req_i.w_data;
                endcase
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Commit FSM with traffic counters, gating and the active configuration set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      gate_q     <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      act_map_q  <= '0;
      act_en_q   <= '0;
      act_port_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      case (state_q)
        StIdle: begin
          if (commit_wr_c) begin
            state_q <= StDrain;
            busy_q  <= 1'b1;
            gate_q  <= '1;
          end
        end
        StDrain: begin
          if (drained_c) state_q <= StCommit;
        end
        StCommit: begin
          act_map_q  <= sh_map_q;
          act_en_q   <= sh_en_q;
          act_port_q <= sh_port_q;
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          gate_q     <= '0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          gate_q  <= '0;
        end
      endcase
    end
  end

  assign gate_o                = gate_q;
  assign busy_o                = busy_q;
  assign addr_map_o            = act_map_q;
  assign en_default_mst_port_o = act_en_q;
  assign default_mst_port_o    = act_port_q;

endmodule

// File: tb/tb_axi_lite_xbar_cfg_ctrl.sv
// Directed bench for axi_lite_xbar_cfg_ctrl: register access, drain/commit sequencing,
// error responses and asynchronous reset during a pending commit.

module tb_axi_lite_xbar_cfg_ctrl;
  import axi_lite_xbar_cfg_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  cfg_req_t        cfg_req;
  cfg_rsp_t        cfg_rsp;
  logic            aw_hs, b_hs, ar_hs, r_hs;
  logic            gate;
  cfg_rule_t [0:0] addr_map;
  logic            en_def;
  logic [0:0][0:0] def_port;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  resp;
  logic [31:0] data;

  axi_lite_xbar_cfg_ctrl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .cfg_req_i             (cfg_req),
    .cfg_rsp_o             (cfg_rsp),
    .aw_hs_i               (aw_hs),
    .b_hs_i                (b_hs),
    .ar_hs_i               (ar_hs),
    .r_hs_i                (r_hs),
    .gate_o                (gate),
    .addr_map_o            (addr_map),
    .en_default_mst_port_o (en_def),
    .default_mst_port_o    (def_port),
    .busy_o                (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns just after the handshake edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [1:0] bresp);
    logic ok;
    ok               = 1'b0;
    cfg_req.aw_addr  = addr;
    cfg_req.w_data   = wdata;
    cfg_req.w_strb   = 4'h0;
    cfg_req.aw_valid = 1'b1;
    cfg_req.w_valid  = 1'b1;
    cfg_req.b_ready  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cfg_rsp.aw_ready && cfg_rsp.w_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("wr_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cfg_req.aw_valid = 1'b0;
    cfg_req.w_valid  = 1'b0;
    check_eq("wr_bvalid", 32'(cfg_rsp.b_valid), 32'd1);
    bresp = cfg_rsp.b_resp;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] rdata,
                          output logic [1:0] rresp);
    logic ok;
    ok               = 1'b0;
    cfg_req.ar_addr  = addr;
    cfg_req.ar_valid = 1'b1;
    cfg_req.r_ready  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cfg_rsp.ar_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("rd_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cfg_req.ar_valid = 1'b0;
    check_eq("rd_rvalid", 32'(cfg_rsp.r_valid), 32'd1);
    rdata = cfg_rsp.r_data;
    rresp = cfg_rsp.r_resp;
  endtask

  task automatic pulse(input logic aw, input logic b, input logic ar, input logic r);
    @(negedge clk);
    aw_hs = aw;
    b_hs  = b;
    ar_hs = ar;
    r_hs  = r;
    @(posedge clk);
    #1;
    aw_hs = 1'b0;
    b_hs  = 1'b0;
    ar_hs = 1'b0;
    r_hs  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_req = '0;
    aw_hs   = 1'b0;
    b_hs    = 1'b0;
    ar_hs   = 1'b0;
    r_hs    = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gate", 32'(gate), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_rsp", 32'({cfg_rsp.aw_ready, cfg_rsp.w_ready, cfg_rsp.ar_ready,
                                  cfg_rsp.b_valid, cfg_rsp.r_valid}), 32'd0);
    check_eq("post_rst_map_idx", addr_map[0].idx, 32'd0);
    check_eq("post_rst_map_end", addr_map[0].end_addr, 32'd0);
    check_eq("post_rst_def", 32'({en_def, def_port[0]}), 32'd0);
    axi_read(32'h4, data, resp);
    check_eq("status_idle", data, 32'd0);

    // Program rule 0 and commit with no traffic: two gated cycles.
    axi_write(32'h100, 32'd1, resp);
    check_eq("wr_rule_idx_resp", 32'(resp), 32'd0);
    axi_write(32'h104, 32'h1000, resp);
    axi_write(32'h108, 32'h2000, resp);
    axi_read(32'h104, data, resp);
    check_eq("rd_rule_start", data, 32'h1000);
    check_eq("shadow_not_active", addr_map[0].start_addr, 32'd0);
    axi_write(32'h0, 32'd1, resp);
    check_eq("commit_resp", 32'(resp), 32'd0);
    check_eq("c1_gate", 32'(gate), 32'd1);
    check_eq("c1_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check_eq("c2_gate", 32'(gate), 32'd1);
    check_eq("c2_map_start", addr_map[0].start_addr, 32'd0);
    @(posedge clk);
    #1;
    check_eq("c3_gate", 32'(gate), 32'd0);
    check_eq("c3_busy", 32'(busy), 32'd0);
    check_eq("c3_idx", addr_map[0].idx, 32'd1);
    check_eq("c3_start", addr_map[0].start_addr, 32'h1000);
    check_eq("c3_end", addr_map[0].end_addr, 32'h2000);

    // Two outstanding writes hold the commit in DRAIN.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    axi_write(32'h0, 32'd1, resp);
    check_eq("d_gate_rise", 32'(gate), 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("d_hold_cnt1", 32'(gate), 32'd1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("d_hold_simul", 32'(busy), 32'd1);
    axi_read(32'h4, data, resp);
    check_eq("status_drain", data, 32'd3);
    axi_write(32'h40, 32'd1, resp);
    check_eq("wr_defport_drain", 32'(resp), 32'd0);
    axi_write(32'h8, 32'hFFFF_FFFF, resp);
    axi_write(32'h104, 32'h3000, resp);
    axi_write(32'h0, 32'd1, resp);
    check_eq("commit_in_drain_resp", 32'(resp), 32'd0);
    check_eq("d_def_not_yet", 32'(def_port[0]), 32'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("d_last_b_gate", 32'(gate), 32'd1);
    check_eq("d_last_b_def", 32'(def_port[0]), 32'd0);
    @(posedge clk);
    #1;
    check_eq("d_done_gate", 32'(gate), 32'd0);
    check_eq("d_done_busy", 32'(busy), 32'd0);
    check_eq("d_done_defport", 32'(def_port[0]), 32'd1);
    check_eq("d_done_en", 32'(en_def), 32'd1);
    check_eq("d_done_start", addr_map[0].start_addr, 32'h3000);
    repeat (2) @(posedge clk);
    #1;
    check_eq("no_extra_commit", 32'({gate, busy}), 32'd0);
    axi_read(32'h8, data, resp);
    check_eq("rd_defen_masked", data, 32'd1);

    // Unmapped addresses.
    axi_read(32'h0FC, data, resp);
    check_eq("rd_0fc_resp", 32'(resp), 32'd2);
    check_eq("rd_0fc_data", data, 32'd0);
    axi_write(32'h110, 32'hDEAD, resp);
    check_eq("wr_rule1_resp", 32'(resp), 32'd2);
    axi_read(32'h100, data, resp);
    check_eq("rule0_unchanged", data, 32'd1);
    check_eq("rule0_rd_resp", 32'(resp), 32'd0);
    axi_read(32'h10C, data, resp);
    check_eq("rd_rule_pad_resp", 32'(resp), 32'd2);
    axi_read(32'h44, data, resp);
    check_eq("rd_defport1_resp", 32'(resp), 32'd2);

    // Asynchronous reset while a read holds the commit in DRAIN.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    axi_write(32'h0, 32'd1, resp);
    check_eq("r_gate", 32'(gate), 32'd1);
    @(posedge clk);
    #1;
    check_eq("r_still_drain", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_gate", 32'(gate), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_idx", addr_map[0].idx, 32'd0);
    check_eq("arst_start", addr_map[0].start_addr, 32'd0);
    check_eq("arst_def", 32'({en_def, def_port[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    axi_read(32'h4, data, resp);
    check_eq("arst_status", data, 32'd0);
    axi_read(32'h100, data, resp);
    check_eq("arst_shadow", data, 32'd0);
    check_eq("arst_gate_after", 32'(gate), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
